grant_locked_mux: RTL and testbench

- Downstream stage of the 4-way fixed-priority arbiter.
- Drives the arbiter's req vector from the client valid lines and captures its one-hot grant.
- Locks ownership of a shared target port to the granted client for a whole multi-beat packet, and releases only on the last beat or a beat-limit timeout.
- Prevents the combinational arbiter from re-granting in the middle of a packet.

---
 rtl/grant_locked_mux_pkg.sv | 27 ++
 rtl/grant_locked_mux_if.sv | 33 +++
 rtl/grant_locked_mux_onehot_encoder_4.sv | 16 +
 rtl/grant_locked_mux.sv | 102 ++++++++++
 tb/tb_grant_locked_mux.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_locked_mux_pkg.sv
// Shared types and helpers for the grant-locked output mux and its arbiter-side neighbours.
// Holds the lock FSM encoding plus one-hot check/encode functions.
package grant_locked_mux_pkg;

  localparam int NUM_CLIENTS = 4;
  localparam int OWNER_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic logic is_onehot(input logic [NUM_CLIENTS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // OR-reduction encode: only meaningful when the input is one-hot.
  function automatic logic [OWNER_W-1:0] onehot_to_bin(input logic [NUM_CLIENTS-1:0] v);
    logic [OWNER_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (v[i]) idx = idx | OWNER_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_locked_mux_if.sv
// Client-side, arbiter-side and target-side signals of the grant-locked mux.
// The slave modport is the mux's view; master is the surrounding environment's view.
interface grant_locked_mux_if
  import grant_locked_mux_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic [NUM_CLIENTS-1:0]        cli_valid;
  logic [NUM_CLIENTS*DATA_W-1:0] cli_data;
  logic [NUM_CLIENTS-1:0]        cli_last;
  logic [NUM_CLIENTS-1:0]        cli_ready;
  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        grant;
  logic                          m_valid;
  logic [DATA_W-1:0]             m_data;
  logic                          m_last;
  logic                          m_ready;
  logic                          busy;
  logic [OWNER_W-1:0]            owner;
  logic                          err;

  modport slave (
    input  cli_valid, cli_data, cli_last, grant, m_ready,
    output cli_ready, req, m_valid, m_data, m_last, busy, owner, err
  );

  modport master (
    output cli_valid, cli_data, cli_last, grant, m_ready,
    input  cli_ready, req, m_valid, m_data, m_last, busy, owner, err
  );

endinterface

// File: rtl/grant_locked_mux_onehot_encoder_4.sv
// Four-input one-hot to binary encoder, shared with other arbiter-side blocks.
// valid_o flags any bit set; onehot_ok_o flags exactly one bit set.
module onehot_encoder_4
  import grant_locked_mux_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] onehot_i,
  output logic [OWNER_W-1:0]     idx_o,
  output logic                   valid_o,
  output logic                   onehot_ok_o
);

  assign idx_o       = onehot_to_bin(onehot_i);
  assign valid_o     = |onehot_i;
  assign onehot_ok_o = is_onehot(onehot_i);

endmodule

// File: rtl/grant_locked_mux.sv
// Locks the shared target port to one arbiter-granted client for a whole packet,
// releasing on the last beat or when the per-lock beat limit is reached.
module grant_locked_mux
  import grant_locked_mux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
)(
  input  logic clk,
  input  logic rst,
  grant_locked_mux_if.slave bus
);

  localparam logic [7:0] MaxBeatsC = 8'(MAX_BEATS);

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [7:0]         count_q, count_d;
  logic               err_q, err_d;

  logic [OWNER_W-1:0] grantIdx;
  logic               grantAny;
  logic               grantOk;
  logic               ownValid;
  logic               ownLast;
  logic               mValid;

  onehot_encoder_4 u_grant_enc (
    .onehot_i    (bus.grant),
    .idx_o       (grantIdx),
    .valid_o     (grantAny),
    .onehot_ok_o (grantOk)
  );

  assign ownValid = bus.cli_valid[owner_q];
  assign ownLast  = bus.cli_last[owner_q];

  // Data path is gated by rst so a packet being abandoned sees no accept in the reset cycle.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    count_d       = count_q;
    err_d         = err_q;
    mValid        = 1'b0;
    bus.req       = '0;
    bus.cli_ready = '0;
    bus.m_valid   = 1'b0;
    bus.m_data    = '0;
    bus.m_last    = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.req = bus.cli_valid;
        if (grantAny) begin
          if (grantOk && ((bus.grant & ~bus.cli_valid) == '0)) begin
            owner_d = grantIdx;
            count_d = '0;
            state_d = LOCK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOCK: begin
        mValid                 = ownValid && !rst;
        bus.m_valid            = mValid;
        bus.m_last             = ownLast;
        bus.cli_ready[owner_q] = bus.m_ready && !rst;
        if (mValid) bus.m_data = bus.cli_data[owner_q*DATA_W +: DATA_W];
        if (mValid && bus.m_ready) begin
          if (count_q < MaxBeatsC) count_d = count_q + 8'd1;
          if (ownLast) begin
            state_d = IDLE;
          end else if ((count_q + 8'd1) >= MaxBeatsC) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy  = (state_q == LOCK);
  assign bus.owner = owner_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_grant_locked_mux.sv
// Bench for grant_locked_mux with a lowest-index-first arbiter and an abstract packet-lock model.
module tb_grant_locked_mux;

  localparam int DW = 8;
  localparam int MB = 4;

  logic clk;
  logic rst;
  logic forceGrantEn;
  logic [3:0] forceGrant;
  int checks;
  int failures;

  bit mLocked;
  int mOwner;
  int mBeats;
  bit mErr;

  grant_locked_mux_if #(.DATA_W(DW)) bus ();

  grant_locked_mux #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-priority arbiter: lowest requesting index wins, unless the bench forces a grant.
  always_comb begin
    bus.grant = forceGrantEn ? forceGrant : (bus.req & (~bus.req + 4'd1));
  end

  function automatic logic [3:0] lowBit(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // Packet-level model: who holds the port, how many beats it has moved, sticky error.
  task automatic modelStep();
    logic [3:0] g;
    if (rst) begin
      mLocked = 0; mOwner = 0; mBeats = 0; mErr = 0;
    end else if (!mLocked) begin
      g = forceGrantEn ? forceGrant : lowBit(bus.cli_valid);
      if (g != 4'b0000) begin
        if ($countones(g) == 1 && (g & ~bus.cli_valid) == 4'b0000) begin
          mLocked = 1;
          mBeats  = 0;
          for (int i = 0; i < 4; i++) if (g[i]) mOwner = i;
        end else begin
          mErr = 1;
        end
      end
    end else if (bus.cli_valid[mOwner] && bus.m_ready) begin
      mBeats++;
      if (bus.cli_last[mOwner]) mLocked = 0;
      else if (mBeats >= MB) begin
        mLocked = 0;
        mErr    = 1;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setData(input int c, input logic [DW-1:0] d);
    bus.cli_data[c*DW +: DW] = d;
  endtask

  task automatic clearInputs();
    bus.cli_valid = '0;
    bus.cli_data  = '0;
    bus.cli_last  = '0;
    bus.m_ready   = 1'b0;
    forceGrantEn  = 1'b0;
    forceGrant    = '0;
  endtask

  task automatic applyReset();
    clearInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++;
    if ({bus.req, bus.busy, bus.m_valid, bus.cli_ready, bus.err} !== 11'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got req=%b busy=%b mv=%b rdy=%b err=%b exp all 0",
               bus.req, bus.busy, bus.m_valid, bus.cli_ready, bus.err);
    end
    checks++;
    if ({bus.owner, bus.m_data, bus.m_last} !== 11'b0) begin
      failures++;
      $display("[TB] FAIL reset_data got owner=%0d data=%h last=%b exp 0", bus.owner, bus.m_data, bus.m_last);
    end
  endtask

  task automatic test_basic_packet();
    applyReset();
    bus.cli_valid = 4'b0110;
    bus.m_ready   = 1'b1;
    setData(1, 8'h11);
    setData(2, 8'h2A);
    #1;
    checks++;
    if (bus.req !== 4'b0110 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_idle got req=%b busy=%b mv=%b exp 0110/0/0", bus.req, bus.busy, bus.m_valid);
    end
    tick();
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.owner !== 2'd1 || bus.req !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL basic_lock got busy=%b owner=%0d req=%b exp 1/1/0000", bus.busy, bus.owner, bus.req);
    end
    for (int b = 0; b < 3; b++) begin
      setData(1, 8'h11 + 8'(b));
      bus.cli_last[1] = (b == 2);
      #1;
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h11 + 8'(b) || bus.cli_ready !== 4'b0010 ||
          bus.m_last !== (b == 2)) begin
        failures++;
        $display("[TB] FAIL basic_beat%0d got mv=%b data=%h rdy=%b last=%b exp 1/%h/0010/%b",
                 b, bus.m_valid, bus.m_data, bus.cli_ready, bus.m_last, 8'h11 + 8'(b), (b == 2));
      end
      tick();
    end
    clearInputs();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_release got busy=%b err=%b exp 0/0", bus.busy, bus.err);
    end
  endtask

  task automatic test_no_preempt();
    applyReset();
    bus.cli_valid = 4'b0100;
    bus.m_ready   = 1'b1;
    setData(0, 8'h05);
    setData(2, 8'h21);
    tick();
    for (int b = 0; b < 3; b++) begin
      setData(2, 8'h21 + 8'(b));
      bus.cli_last[2] = (b == 2);
      bus.cli_valid   = (b >= 1) ? 4'b0101 : 4'b0100;
      #1;
      checks++;
      if (bus.cli_ready !== 4'b0100 || bus.owner !== 2'd2 || bus.req !== 4'b0000 ||
          bus.m_data !== 8'h21 + 8'(b)) begin
        failures++;
        $display("[TB] FAIL preempt_beat%0d got rdy=%b owner=%0d req=%b data=%h exp 0100/2/0000/%h",
                 b, bus.cli_ready, bus.owner, bus.req, bus.m_data, 8'h21 + 8'(b));
      end
      tick();
    end
    bus.cli_last  = '0;
    bus.cli_valid = 4'b0001;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.req !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL preempt_gap got busy=%b req=%b exp 0/0001", bus.busy, bus.req);
    end
    tick();
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.owner !== 2'd0) begin
      failures++;
      $display("[TB] FAIL preempt_next got busy=%b owner=%0d exp 1/0", bus.busy, bus.owner);
    end
  endtask

  task automatic test_backpressure();
    int beatIdx;
    applyReset();
    bus.cli_valid = 4'b1000;
    setData(3, 8'h31);
    tick();
    beatIdx = 0;
    for (int cyc = 0; cyc < 12 && beatIdx < 4; cyc++) begin
      setData(3, 8'h31 + 8'(beatIdx));
      bus.cli_last[3] = (beatIdx == 3);
      bus.m_ready     = (cyc % 2 == 0);
      #1;
      checks++;
      if (bus.owner !== 2'd3 || bus.busy !== 1'b1 || bus.m_data !== 8'h31 + 8'(beatIdx) ||
          bus.cli_ready !== {bus.m_ready, 3'b000}) begin
        failures++;
        $display("[TB] FAIL bp_cyc%0d got owner=%0d busy=%b data=%h rdy=%b exp 3/1/%h/%b000",
                 cyc, bus.owner, bus.busy, bus.m_data, bus.cli_ready, 8'h31 + 8'(beatIdx), bus.m_ready);
      end
      if (bus.m_ready) beatIdx++;
      tick();
    end
    clearInputs();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release got busy=%b err=%b exp 0/0", bus.busy, bus.err);
    end
  endtask

  task automatic test_max_beats();
    applyReset();
    bus.cli_valid = 4'b0001;
    bus.m_ready   = 1'b1;
    tick();
    for (int b = 0; b < MB; b++) begin
      setData(0, 8'h40 + 8'(b));
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.m_valid !== 1'b1 || bus.err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL maxb_beat%0d got busy=%b mv=%b err=%b exp 1/1/0", b, bus.busy, bus.m_valid, bus.err);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b1 || bus.req !== 4'b0001 || bus.cli_ready !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL maxb_force got busy=%b err=%b req=%b rdy=%b exp 0/1/0001/0000",
               bus.busy, bus.err, bus.req, bus.cli_ready);
    end
    tick();
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.owner !== 2'd0 || bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL maxb_rearb got busy=%b owner=%0d err=%b exp 1/0/1", bus.busy, bus.owner, bus.err);
    end
  endtask

  task automatic test_bad_grant();
    applyReset();
    bus.cli_valid = 4'b0011;
    forceGrantEn  = 1'b1;
    forceGrant    = 4'b0011;
    tick();
    clearInputs();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bad_multi got busy=%b err=%b exp 0/1", bus.busy, bus.err);
    end
    applyReset();
    #1;
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_clear got err=%b exp 0", bus.err);
    end
    bus.cli_valid = 4'b0001;
    forceGrantEn  = 1'b1;
    forceGrant    = 4'b0100;
    tick();
    clearInputs();
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bad_noreq got busy=%b err=%b exp 0/1", bus.busy, bus.err);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    bus.cli_valid = 4'b0100;
    bus.m_ready   = 1'b1;
    tick();
    setData(2, 8'h51);
    tick();
    setData(2, 8'h52);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cli_ready !== 4'b0000 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_gate got rdy=%b mv=%b exp 0000/0", bus.cli_ready, bus.m_valid);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.req !== 4'b0100 || bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_after got busy=%b req=%b err=%b exp 0/0100/0", bus.busy, bus.req, bus.err);
    end
  endtask

  task automatic test_random();
    logic [3:0] expReq, expRdy;
    logic expValid, expLast;
    logic [DW-1:0] expData;
    applyReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.cli_valid = 4'($urandom);
      bus.cli_data  = $urandom;
      for (int i = 0; i < 4; i++) bus.cli_last[i] = ($urandom_range(0, 3) == 0);
      bus.m_ready   = ($urandom_range(0, 3) != 0);
      #1;
      expReq   = mLocked ? 4'b0000 : bus.cli_valid;
      expValid = mLocked && bus.cli_valid[mOwner];
      expRdy   = mLocked ? (4'(bus.m_ready) << mOwner) : 4'b0000;
      expData  = expValid ? bus.cli_data[mOwner*DW +: DW] : '0;
      expLast  = mLocked ? bus.cli_last[mOwner] : 1'b0;
      checks++;
      if (bus.req !== expReq || bus.cli_ready !== expRdy) begin
        failures++;
        $display("[TB] FAIL rand_ctl cyc=%0d got req=%b rdy=%b exp %b/%b", cyc, bus.req, bus.cli_ready, expReq, expRdy);
      end
      checks++;
      if (bus.m_valid !== expValid || bus.m_data !== expData || bus.m_last !== expLast) begin
        failures++;
        $display("[TB] FAIL rand_data cyc=%0d got mv=%b data=%h last=%b exp %b/%h/%b",
                 cyc, bus.m_valid, bus.m_data, bus.m_last, expValid, expData, expLast);
      end
      checks++;
      if (bus.busy !== mLocked || bus.err !== mErr || (mLocked && bus.owner !== 2'(mOwner))) begin
        failures++;
        $display("[TB] FAIL rand_state cyc=%0d got busy=%b err=%b owner=%0d exp %b/%b/%0d",
                 cyc, bus.busy, bus.err, bus.owner, mLocked, mErr, mOwner);
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mLocked  = 0; mOwner = 0; mBeats = 0; mErr = 0;
    rst      = 1'b1;
    clearInputs();
    @(negedge clk);
    test_reset();
    test_basic_packet();
    test_no_preempt();
    test_backpressure();
    test_max_beats();
    test_bad_grant();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
